if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the MIPS core.
- Generates the PC and drives a single-outstanding request/ack instruction bus.
- Presents the fetched instruction to ID; id_instr_o is the instruction word the hazard control unit decodes.
- Obeys the control unit's PC/IF-ID stall and IF/ID flush, and accepts branch/exception redirects.

---
 rtl/if_stage.sv | 215 +++++++++++++++++++++
 tb/tb_if_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose:
//   Generates the fetch PC and drives a single-outstanding req/ack instruction
//   bus. Fetched words are placed in the IF/ID register for the decode stage.
//   The stage honours the PC/IF-ID stall and the IF/ID flush, and accepts
//   redirects (branch, ERET, exception vector).
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   pa_pc_ifid_i     stall: hold PC and IF/ID
//   wash_ifid_i      flush IF/ID to a bubble
//   redirect_i       load redirect_pc_i as the next fetch PC
//   redirect_pc_i    redirect target
//   ibus_req_o       fetch request
//   ibus_addr_o      fetch address, stable while req is high until ack
//   ibus_ack_i       read data valid this cycle (may come in the request cycle)
//   ibus_rdata_i     instruction word, valid with ack
//   id_instr_o       IF/ID instruction
//   id_pc_o          IF/ID PC
//   id_valid_o       IF/ID holds a real instruction
//   id_adel_o        IF/ID fetch-address error (IF_ADDR_EXC_EN builds only)
//   fetch_busy_o     fetch waiting on the bus
//
// Build option:
//   IF_ADDR_EXC_EN   when defined, misaligned PCs raise id_adel_o instead of
//                    being silently aligned on redirect.

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pa_pc_ifid_i,
  input  logic        wash_ifid_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
`ifdef IF_ADDR_EXC_EN
  output logic        id_adel_o,
`endif
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q;
  logic        req_q;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] instr_q, id_pc_q;
  logic        valid_q;

  // Candidate IF/ID load for this cycle; new_valid=0 means a bubble.
  logic [31:0] new_instr, new_pc;
  logic        new_valid;

  logic        ack;
  logic        pc_mis, next_mis;
  logic [31:0] redir_target;

`ifdef IF_ADDR_EXC_EN
  logic        adel_q, new_adel;
  assign redir_target = redirect_pc_i;
  assign pc_mis       = (pc_q[1:0] != 2'b00);
  assign next_mis     = (pc_d[1:0] != 2'b00);
`else
  assign redir_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign pc_mis       = 1'b0;
  assign next_mis     = 1'b0;
`endif

  // Only an ack for a request we actually issued counts.
  assign ack = ibus_ack_i & req_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;
    new_valid    = 1'b0;
    new_instr    = NOP_INSTR;
    new_pc       = id_pc_q;
`ifdef IF_ADDR_EXC_EN
    new_adel     = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (pc_mis) begin
          // No bus cycle: hand an address-error marker to ID and wait for
          // the exception redirect.
          new_valid = 1'b1;
          new_instr = NOP_INSTR;
          new_pc    = pc_q;
`ifdef IF_ADDR_EXC_EN
          new_adel  = 1'b1;
`endif
        end else if (ack) begin
          pc_d = pc_q + 32'd4;
          if (!redirect_i) begin
            if (pa_pc_ifid_i) begin
              // IF/ID is frozen, so park the word until the stall drops.
              hold_instr_d = ibus_rdata_i;
              hold_pc_d    = pc_q;
              hold_valid_d = 1'b1;
              state_d      = S_HOLD;
            end else begin
              new_valid = 1'b1;
              new_instr = ibus_rdata_i;
              new_pc    = pc_q;
            end
          end
        end else if (redirect_i) begin
          // Request is in flight with the old address; it must complete.
          state_d = S_DISCARD;
        end
        if (redirect_i) pc_d = redir_target;
      end
      S_HOLD: begin
        if (redirect_i) begin
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (!pa_pc_ifid_i) begin
          new_valid    = hold_valid_q;
          new_instr    = hold_instr_q;
          new_pc       = hold_pc_q;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end
        if (redirect_i) pc_d = redir_target;
      end
      S_DISCARD: begin
        if (ack) state_d = S_REQ;
        if (redirect_i) pc_d = redir_target;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
      hold_valid_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= 32'h0;
      valid_q      <= 1'b0;
`ifdef IF_ADDR_EXC_EN
      adel_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
      req_q        <= ((state_d == S_REQ) && !next_mis) || (state_d == S_DISCARD);
      // While discarding, the bus still sees the abandoned address.
      if (state_d != S_DISCARD) addr_q <= pc_d;
      if (!pa_pc_ifid_i) begin
        if (wash_ifid_i || !new_valid) begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
`ifdef IF_ADDR_EXC_EN
          adel_q  <= 1'b0;
`endif
        end else begin
          instr_q <= new_instr;
          id_pc_q <= new_pc;
          valid_q <= 1'b1;
`ifdef IF_ADDR_EXC_EN
          adel_q  <= new_adel;
`endif
        end
      end
    end
  end

  assign ibus_req_o   = req_q;
  assign ibus_addr_o  = addr_q;
  assign id_instr_o   = instr_q;
  assign id_pc_o      = id_pc_q;
  assign id_valid_o   = valid_q;
`ifdef IF_ADDR_EXC_EN
  assign id_adel_o    = adel_q;
`endif
  assign fetch_busy_o = ((state_q == S_REQ) && req_q && !ibus_ack_i) ||
                        (state_q == S_DISCARD);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, wash, redirect;
  logic [31:0] redirect_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] id_instr, id_pc;
  logic        id_valid;
  logic        fetch_busy;
`ifdef IF_ADDR_EXC_EN
  logic        id_adel;
`endif

  logic        zw;
  logic        ack_drv;
  logic [31:0] rdata_drv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Zero-wait memory: ack follows req, data = address with upper half inverted.
  assign ibus_ack   = zw ? ibus_req : ack_drv;
  assign ibus_rdata = zw ? (ibus_addr ^ 32'hFFFF_0000) : rdata_drv;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pa_pc_ifid_i  (stall),
    .wash_ifid_i   (wash),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .ibus_req_o    (ibus_req),
    .ibus_addr_o   (ibus_addr),
    .ibus_ack_i    (ibus_ack),
    .ibus_rdata_i  (ibus_rdata),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_valid_o    (id_valid),
`ifdef IF_ADDR_EXC_EN
    .id_adel_o     (id_adel),
`endif
    .fetch_busy_o  (fetch_busy)
  );

  // Leaves the DUT in REQ with the first request (0xBFC00000) on the bus.
  task automatic boot();
    zw = 1'b0; ack_drv = 1'b0; rdata_drv = 32'h0;
    stall = 1'b0; wash = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    zw = 1'b0; ack_drv = 1'b0; rdata_drv = 32'h0;
    stall = 1'b0; wash = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", ibus_req); end
    checks++; if (ibus_addr !== 32'hBFC00000) begin errors++; $display("FAIL rst_addr got %h exp bfc00000", ibus_addr); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 00000000", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", id_pc); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", id_valid); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", fetch_busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", ibus_req); end
    @(negedge clk);
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", ibus_req); end
    checks++; if (ibus_addr !== 32'hBFC00000) begin errors++; $display("FAIL first_addr got %h exp bfc00000", ibus_addr); end
  endtask

  task automatic test_zero_wait();
    boot();
    zw = 1'b1;
    #1;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL zw_busy got %b exp 0", fetch_busy); end
    @(negedge clk);
    checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL zw_pc0 got %h exp bfc00000", id_pc); end
    checks++; if (id_instr !== 32'h403F0000) begin errors++; $display("FAIL zw_instr0 got %h exp 403f0000", id_instr); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid0 got %b exp 1", id_valid); end
    @(negedge clk);
    checks++; if (id_pc !== 32'hBFC00004) begin errors++; $display("FAIL zw_pc1 got %h exp bfc00004", id_pc); end
    checks++; if (id_instr !== 32'h403F0004) begin errors++; $display("FAIL zw_instr1 got %h exp 403f0004", id_instr); end
    @(negedge clk);
    checks++; if (id_pc !== 32'hBFC00008) begin errors++; $display("FAIL zw_pc2 got %h exp bfc00008", id_pc); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid2 got %b exp 1", id_valid); end
    zw = 1'b0;
  endtask

  task automatic test_wait_states();
    boot();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ibus_addr !== 32'hBFC00000) begin errors++; $display("FAIL ws_addr[%0d] got %h exp bfc00000", k, ibus_addr); end
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL ws_busy[%0d] got %b exp 1", k, fetch_busy); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got %b exp 0", k, id_valid); end
      @(negedge clk);
    end
    ack_drv = 1'b1; rdata_drv = 32'h11112222;
    #1;
    checks++; if (ibus_addr !== 32'hBFC00000) begin errors++; $display("FAIL ws_addr_ack got %h exp bfc00000", ibus_addr); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL ws_busy_ack got %b exp 0", fetch_busy); end
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (id_instr !== 32'h11112222) begin errors++; $display("FAIL ws_instr got %h exp 11112222", id_instr); end
    checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL ws_pc got %h exp bfc00000", id_pc); end
    checks++; if (ibus_addr !== 32'hBFC00004) begin errors++; $display("FAIL ws_next_addr got %h exp bfc00004", ibus_addr); end
  endtask

  task automatic test_stall();
    boot();
    ack_drv = 1'b1; rdata_drv = 32'hAAAA0000;
    @(negedge clk);
    stall = 1'b1; rdata_drv = 32'h24080005;
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL st_req got %b exp 0", ibus_req); end
    checks++; if (id_instr !== 32'hAAAA0000) begin errors++; $display("FAIL st_keep_instr got %h exp aaaa0000", id_instr); end
    checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL st_keep_pc got %h exp bfc00000", id_pc); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL st_busy got %b exp 0", fetch_busy); end
    @(negedge clk);
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL st_req2 got %b exp 0", ibus_req); end
    checks++; if (id_instr !== 32'hAAAA0000) begin errors++; $display("FAIL st_keep_instr2 got %h exp aaaa0000", id_instr); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (id_instr !== 32'h24080005) begin errors++; $display("FAIL st_rel_instr got %h exp 24080005", id_instr); end
    checks++; if (id_pc !== 32'hBFC00004) begin errors++; $display("FAIL st_rel_pc got %h exp bfc00004", id_pc); end
    checks++; if (ibus_addr !== 32'hBFC00008) begin errors++; $display("FAIL st_rel_addr got %h exp bfc00008", ibus_addr); end
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL st_rel_req got %b exp 1", ibus_req); end
  endtask

  task automatic test_redirect_pending();
    boot();
    ack_drv = 1'b1; rdata_drv = 32'h01010101;
    repeat (4) @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (ibus_addr !== 32'hBFC00010) begin errors++; $display("FAIL rd_pend_addr got %h exp bfc00010", ibus_addr); end
    redirect = 1'b1; redirect_pc = 32'h80000180;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (ibus_addr !== 32'hBFC00010) begin errors++; $display("FAIL rd_hold_addr got %h exp bfc00010", ibus_addr); end
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL rd_hold_req got %b exp 1", ibus_req); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", fetch_busy); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_valid0 got %b exp 0", id_valid); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_valid1 got %b exp 0", id_valid); end
    ack_drv = 1'b1; rdata_drv = 32'hDEADBEEF;
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_stale_valid got %b exp 0", id_valid); end
    checks++; if (ibus_addr !== 32'h80000180) begin errors++; $display("FAIL rd_new_addr got %h exp 80000180", ibus_addr); end
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL rd_new_req got %b exp 1", ibus_req); end
    ack_drv = 1'b1; rdata_drv = 32'h33334444;
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (id_pc !== 32'h80000180) begin errors++; $display("FAIL rd_tgt_pc got %h exp 80000180", id_pc); end
    checks++; if (id_instr !== 32'h33334444) begin errors++; $display("FAIL rd_tgt_instr got %h exp 33334444", id_instr); end
  endtask

  task automatic test_wash();
    boot();
    ack_drv = 1'b1; rdata_drv = 32'h55556666;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wa_pre_valid got %b exp 1", id_valid); end
    wash = 1'b1; rdata_drv = 32'h77778888;
    @(negedge clk);
    wash = 1'b0;
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL wa_instr got %h exp 00000000", id_instr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wa_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL wa_pc got %h exp bfc00000", id_pc); end
    checks++; if (ibus_addr !== 32'hBFC00008) begin errors++; $display("FAIL wa_addr got %h exp bfc00008", ibus_addr); end
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (id_pc !== 32'hBFC00008) begin errors++; $display("FAIL wa_next_pc got %h exp bfc00008", id_pc); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wa_next_valid got %b exp 1", id_valid); end
  endtask

  task automatic test_stall_wash();
    boot();
    ack_drv = 1'b1; rdata_drv = 32'h9999AAAA;
    @(negedge clk);
    stall = 1'b1; wash = 1'b1; ack_drv = 1'b0;
    @(negedge clk);
    checks++; if (id_instr !== 32'h9999AAAA) begin errors++; $display("FAIL sw_instr got %h exp 9999aaaa", id_instr); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got %b exp 1", id_valid); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL sw_busy got %b exp 1", fetch_busy); end
    stall = 1'b0; wash = 1'b0;
  endtask

  task automatic test_wrap();
    boot();
    ack_drv = 1'b1; rdata_drv = 32'hBAD0BAD0;
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    redirect = 1'b0; rdata_drv = 32'h12345678;
    checks++; if (ibus_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_addr got %h exp fffffffc", ibus_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wr_drop_valid got %b exp 0", id_valid); end
    @(negedge clk);
    ack_drv = 1'b0;
    checks++; if (id_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_pc got %h exp fffffffc", id_pc); end
    checks++; if (id_instr !== 32'h12345678) begin errors++; $display("FAIL wr_instr got %h exp 12345678", id_instr); end
    checks++; if (ibus_addr !== 32'h00000000) begin errors++; $display("FAIL wr_wrap_addr got %h exp 00000000", ibus_addr); end
  endtask

  task automatic test_misaligned();
    boot();
    redirect = 1'b1; redirect_pc = 32'h80000182;
    @(negedge clk);
    redirect = 1'b0; ack_drv = 1'b1; rdata_drv = 32'h0BAD0BAD;
    @(negedge clk);
    ack_drv = 1'b0;
`ifdef IF_ADDR_EXC_EN
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL ma_req got %b exp 0", ibus_req); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL ma_busy got %b exp 0", fetch_busy); end
    @(negedge clk);
    checks++; if (id_adel !== 1'b1) begin errors++; $display("FAIL ma_adel got %b exp 1", id_adel); end
    checks++; if (id_pc !== 32'h80000182) begin errors++; $display("FAIL ma_pc got %h exp 80000182", id_pc); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ma_valid got %b exp 1", id_valid); end
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL ma_req2 got %b exp 0", ibus_req); end
`else
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL al_req got %b exp 1", ibus_req); end
    checks++; if (ibus_addr !== 32'h80000180) begin errors++; $display("FAIL al_addr got %h exp 80000180", ibus_addr); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_wash();
    test_stall_wash();
    test_wrap();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
